// File: rtl/ysyx_24090018_wbu_pkg.sv
// ysyx_24090018_wbu_pkg
//   Shared definitions for the JX500 writeback unit: the WBU halt-FSM state
//   encodings (2 bits) and the common all-zero word.
package ysyx_24090018_wbu_pkg;

    localparam logic [31:0] ysyx_24090018_ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        WBU_RUN   = 2'd0,
        WBU_DRAIN = 2'd1,
        WBU_HALT  = 2'd2
    } wbu_state_e;

endpackage

// File: rtl/ysyx_24090018_regfile.sv
// ysyx_24090018_regfile
//   Integer register file: 2**ADDR_WIDTH entries, one synchronous write port
//   that never touches x0, and two combinational read ports.
//   Ports:
//     clk, rst            clock, synchronous active-high reset (clears array)
//     i_wen/i_waddr/i_wdata   write port
//     i_raddr1/o_rdata1   read port 1 (index 0 reads as zero)
//     i_raddr2/o_rdata2   read port 2 (index 0 reads as zero)
module ysyx_24090018_regfile
    import ysyx_24090018_wbu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wen,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr1,
    input  logic [ADDR_WIDTH-1:0] i_raddr2,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic [DATA_WIDTH-1:0] o_rdata2
);
    localparam int NREG = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wen && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/ysyx_24090018_wbu.sv
// ysyx_24090018_wbu
//   Writeback unit. Accepts executed instructions from the EXU over a
//   valid/ready handshake, stages them for one cycle in wb_q, retires them into
//   the register file, bypasses the staged result to the IDU read ports, and
//   stops the core on ebreak.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     exu_valid_i/exu_ready_o  EXU handshake (ready depends only on state)
//     exu_pc_i, exu_rd_i, exu_wen_i, exu_wdata_i, exu_ebreak_i  instruction
//     raddr1_i/rdata1_o, raddr2_i/rdata2_o   IDU read ports with bypass
//     commit_o, commit_cnt_o   retire pulse and wrapping retire count
//     halt_o, halt_pc_o        sticky halt flag and PC of the halting ebreak
//
//   state | meaning
//   RUN   | accepting one instruction per cycle
//   DRAIN | ebreak accepted and sitting in wb_q; retires on the next edge
//   HALT  | core stopped; no transfers or writes until reset
module ysyx_24090018_wbu
    import ysyx_24090018_wbu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid_i,
    output logic                  exu_ready_o,
    input  logic [DATA_WIDTH-1:0] exu_pc_i,
    input  logic [ADDR_WIDTH-1:0] exu_rd_i,
    input  logic                  exu_wen_i,
    input  logic [DATA_WIDTH-1:0] exu_wdata_i,
    input  logic                  exu_ebreak_i,
    input  logic [ADDR_WIDTH-1:0] raddr1_i,
    input  logic [ADDR_WIDTH-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [DATA_WIDTH-1:0] rdata2_o,
    output logic                  commit_o,
    output logic [31:0]           commit_cnt_o,
    output logic                  halt_o,
    output logic [DATA_WIDTH-1:0] halt_pc_o
);
    wbu_state_e r_state, w_state_nxt;

    logic                  r_wb_valid;
    logic [DATA_WIDTH-1:0] r_wb_pc;
    logic [ADDR_WIDTH-1:0] r_wb_rd;
    logic                  r_wb_wen;
    logic [DATA_WIDTH-1:0] r_wb_wdata;
    logic                  r_wb_ebreak;

    logic [31:0]           r_commit_cnt;
    logic [31:0]           w_commit_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_halt_pc;

    logic                  w_xfer;
    logic                  w_byp1, w_byp2;
    logic [DATA_WIDTH-1:0] w_rf_rdata1, w_rf_rdata2;

    assign exu_ready_o = (r_state == WBU_RUN);
    assign w_xfer      = exu_valid_i && exu_ready_o;

    // Stage register: loaded on a transfer, emptied otherwise.
    always_ff @(posedge clk) begin
        if (rst || !w_xfer) begin
            r_wb_valid  <= 1'b0;
            r_wb_pc     <= '0;
            r_wb_rd     <= '0;
            r_wb_wen    <= 1'b0;
            r_wb_wdata  <= '0;
            r_wb_ebreak <= 1'b0;
        end else begin
            r_wb_valid  <= 1'b1;
            r_wb_pc     <= exu_pc_i;
            r_wb_rd     <= exu_rd_i;
            r_wb_wen    <= exu_wen_i;
            r_wb_wdata  <= exu_wdata_i;
            r_wb_ebreak <= exu_ebreak_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WBU_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            WBU_RUN:   if (w_xfer && exu_ebreak_i) w_state_nxt = WBU_DRAIN;
            WBU_DRAIN: if (r_wb_valid && r_wb_ebreak) w_state_nxt = WBU_HALT;
            WBU_HALT:  w_state_nxt = WBU_HALT;
            default:   w_state_nxt = WBU_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_halt_pc <= '0;
        end else if ((r_state == WBU_DRAIN) && r_wb_valid && r_wb_ebreak) begin
            r_halt_pc <= r_wb_pc;
        end
    end

    // The counter is written every cycle so it always follows its next-value net.
    assign w_commit_cnt_nxt = r_wb_valid ? (r_commit_cnt + 32'd1) : r_commit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_cnt <= ysyx_24090018_ZeroWord;
        end else begin
            r_commit_cnt <= w_commit_cnt_nxt;
        end
    end

    ysyx_24090018_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_wen    (r_wb_valid && r_wb_wen),
        .i_waddr  (r_wb_rd),
        .i_wdata  (r_wb_wdata),
        .i_raddr1 (raddr1_i),
        .i_raddr2 (raddr2_i),
        .o_rdata1 (w_rf_rdata1),
        .o_rdata2 (w_rf_rdata2)
    );

    // Forward the staged result so a read in the cycle before the array
    // update is never stale; x0 is excluded.
    assign w_byp1 = r_wb_valid && r_wb_wen && (r_wb_rd == raddr1_i) && (raddr1_i != '0);
    assign w_byp2 = r_wb_valid && r_wb_wen && (r_wb_rd == raddr2_i) && (raddr2_i != '0);

    assign rdata1_o = w_byp1 ? r_wb_wdata : w_rf_rdata1;
    assign rdata2_o = w_byp2 ? r_wb_wdata : w_rf_rdata2;

    // A retire in a reset cycle is discarded, so it must not pulse either.
    assign commit_o     = r_wb_valid && !rst;
    assign commit_cnt_o = r_commit_cnt;
    assign halt_o       = (r_state == WBU_HALT);
    assign halt_pc_o    = r_halt_pc;

endmodule
